seven_seg_rx: RTL and testbench
===============================

SEVEN_SEG_RX -- requirements
Module: seven_seg_rx

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed digits observed, legal range 1..8.
REQ-002 Parameter STABLE_CYCLES, default 4: consecutive identical synchronized samples required before capture, legal range 2..255.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 segment_in  input  7  segment lines, bit0=a .. bit6=g, active-high, asynchronous to clk.
REQ-006 anode_in  input  NUM_DIGITS  digit select, one-hot active-high, asynchronous to clk.
REQ-007 clr_err  input  1  synchronous clear of both sticky error flags.
REQ-008 value_out  output  4*NUM_DIGITS  last complete frame, digit i in bits [4i+3:4i].
REQ-009 digit_valid  output  NUM_DIGITS  per-digit "captured in current frame" mask.
REQ-010 frame_valid  output  1  one-cycle pulse when value_out updates.
REQ-011 err_pattern  output  1  sticky: captured segment pattern not in decode table.
REQ-012 err_anode  output  1  sticky: captured anode value had more than one bit set.

Function
REQ-013 Decode table (segment hex -> nibble) SHALL be: 3F->0, 06->1, 5B->2, 4F->3, 66->4, 6D->5, 7D->6, 07->7, 7F->8, 6F->9, 77->A, 7C->B, 39->C, 5E->D, 79->E, 71->F; all other 112 patterns illegal.
REQ-014 segment_in and anode_in SHALL each pass through a 2-flop synchronizer before any use.
REQ-015 Stability counter SHALL reset to 1 on any change of synchronized {anode, segment} versus the previous sample, else increment, saturating at STABLE_CYCLES.
REQ-016 Capture event SHALL fire exactly once per stable period, on the edge the counter transitions to STABLE_CYCLES; saturated counter SHALL NOT re-fire.
REQ-017 Latency: for an input held from cycle 0, digit register and digit_valid bit SHALL be visible at cycle STABLE_CYCLES+2.
REQ-018 Capture with anode all-zero (blanking): no write, no error.
REQ-019 Capture with anode one-hot at index i and legal pattern: digit register i <= decoded nibble, digit_valid[i] <= 1; rewriting an already-valid digit overwrites it.
REQ-020 Capture with anode one-hot and illegal pattern: err_pattern <= 1, digit i and digit_valid[i] unchanged.
REQ-021 Capture with anode multi-hot: err_anode <= 1, no digit write, pattern not checked.
REQ-022 When digit_valid becomes all-ones, on the next edge: value_out <= all digit registers, frame_valid <= 1 for one cycle, digit_valid <= 0.
REQ-023 A capture arriving on the same edge as the frame commit SHALL be applied after the clear (its digit_valid bit survives).
REQ-024 clr_err and a new error event on the same edge: error flag SHALL end set.
REQ-025 value_out SHALL hold between frames; partial frames never reach value_out.

Reset
REQ-026 rst_n low SHALL immediately clear synchronizers, counter, digit registers, digit_valid, value_out, frame_valid, err_pattern, err_anode to 0.
REQ-027 Reset mid-frame SHALL discard partial digits; first frame after release requires all NUM_DIGITS captures.

Structure
REQ-028 Shared package seven_seg_pkg SHALL hold the 16-entry segment constant table, segment bit-index constants and the illegal-pattern marker.
REQ-029 Combinational inverse lookup SHALL be a sub-module seven_seg_decode (7-bit in -> 4-bit value + legal flag), driven from the package table.
REQ-030 Synchronizer, stability counter, digit bank and frame/commit logic reside in seven_seg_rx.

Verification
REQ-031 Drive anode=0001..1000 with 3F,06,5B,4F, each held 8 cycles -> frame_valid pulse once, value_out=16'h3210, no errors.
REQ-032 Hold anode=0001, segment=7F for 40 cycles -> exactly one capture, digit0=8, digit_valid=0001, no frame_valid.
REQ-033 Toggle segment every 2 cycles (STABLE_CYCLES=4) -> no capture, digit_valid stays 0.
REQ-034 anode=0010, segment=00 held 8 cycles -> err_pattern=1, digit_valid[1]=0; clr_err pulse -> err_pattern=0.
REQ-035 anode=0011 held 8 cycles -> err_anode=1, no digit write; anode=0000 held -> no change.
REQ-036 Assert rst_n low after 3 of 4 digits captured -> all outputs 0 immediately; next full scan of 71,79,5E,39 -> value_out=16'hCDEF.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment receiver: glyph table and segment bit positions.
package seven_seg_pkg;

  // Segment line positions within the 7-bit segment bus.
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;
  localparam int SEG_W = 7;

  // Glyph for each hex value; entry i is the pattern that displays nibble i.
  localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // Value reported by the decoder alongside legal=0 for an unknown pattern.
  localparam logic [3:0] NIBBLE_ILLEGAL = 4'h0;

  // Forward lookup, handy when building stimulus or debug views.
  function automatic logic [SEG_W-1:0] seg_glyph(input logic [3:0] value);
    return SEG_TABLE[value];
  endfunction

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational inverse glyph lookup: segment pattern -> hex nibble plus legal flag.
module seven_seg_decode
  import seven_seg_pkg::*;
(
  input  logic [SEG_W-1:0] segment,
  output logic [3:0]       value,
  output logic             legal
);

  // Search the glyph table; at most one entry can match since all glyphs differ.
  always_comb begin
    value = NIBBLE_ILLEGAL;
    legal = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (segment == SEG_TABLE[i]) begin
        value = 4'(i);
        legal = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seven_seg_rx.sv
// Seven-segment display snooper: synchronizes multiplexed segment/anode lines,
// waits for a stable sample, decodes each digit and publishes complete frames.
module seven_seg_rx
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [SEG_W-1:0]        segment_in,
  input  logic [NUM_DIGITS-1:0]   anode_in,
  input  logic                    clr_err,
  output logic [4*NUM_DIGITS-1:0] value_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    frame_valid,
  output logic                    err_pattern,
  output logic                    err_anode
);

  localparam int              CNT_W   = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  logic [SEG_W-1:0]             seg_meta, seg_sync, seg_prev;
  logic [NUM_DIGITS-1:0]        an_meta, an_sync, an_prev;
  logic [CNT_W-1:0]             stable_cnt, cnt_next;
  logic                         sample_changed;
  logic                         capture;
  int                           an_ones;
  logic                         an_one_hot, an_multi;
  logic [3:0]                   dec_value;
  logic                         dec_legal;
  logic                         digit_write;
  logic                         frame_commit;
  logic [NUM_DIGITS-1:0]        valid_next;
  logic [NUM_DIGITS-1:0][3:0]   digit_reg;

  // Two-flop synchronizers plus a copy of the previous synchronized sample for change detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_meta <= '0;
      seg_sync <= '0;
      seg_prev <= '0;
      an_meta  <= '0;
      an_sync  <= '0;
      an_prev  <= '0;
    end else begin
      seg_meta <= segment_in;
      seg_sync <= seg_meta;
      seg_prev <= seg_sync;
      an_meta  <= anode_in;
      an_sync  <= an_meta;
      an_prev  <= an_sync;
    end
  end

  // Stability tracking: restart at 1 on any change, saturate at the threshold,
  // and fire a single capture on the edge the threshold is first reached.
  always_comb begin
    sample_changed = ({an_sync, seg_sync} != {an_prev, seg_prev});
    if (sample_changed)
      cnt_next = CNT_W'(1);
    else if (stable_cnt == CNT_MAX)
      cnt_next = stable_cnt;
    else
      cnt_next = stable_cnt + CNT_W'(1);
    capture = (cnt_next == CNT_MAX) && (stable_cnt != CNT_MAX);
  end

  // Stability counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stable_cnt <= '0;
    else        stable_cnt <= cnt_next;
  end

  seven_seg_decode u_decode (
    .segment (seg_sync),
    .value   (dec_value),
    .legal   (dec_legal)
  );

  // Classify the captured anode and decide what the capture does; a commit clears
  // the valid mask first so a same-edge capture keeps its bit.
  always_comb begin
    an_ones      = $countones(an_sync);
    an_one_hot   = (an_ones == 1);
    an_multi     = (an_ones > 1);
    digit_write  = capture && an_one_hot && dec_legal;
    frame_commit = &digit_valid;
    valid_next   = (frame_commit ? '0 : digit_valid) | (digit_write ? an_sync : '0);
  end

  // Digit bank, frame commit and sticky error flags (a new error wins over clr_err).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_reg   <= '0;
      digit_valid <= '0;
      value_out   <= '0;
      frame_valid <= 1'b0;
      err_pattern <= 1'b0;
      err_anode   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (digit_write && an_sync[i]) digit_reg[i] <= dec_value;
      end
      digit_valid <= valid_next;
      if (frame_commit) value_out <= digit_reg;
      frame_valid <= frame_commit;
      err_pattern <= (err_pattern && !clr_err) || (capture && an_one_hot && !dec_legal);
      err_anode   <= (err_anode && !clr_err) || (capture && an_multi);
    end
  end

endmodule

// File: tb/tb_seven_seg_rx.sv
// Bench for seven_seg_rx: directed scenarios followed by randomized display scans,
// all checked against a hold-level behavioural model.
module tb_seven_seg_rx;

  localparam int N = 4;
  localparam int S = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [6:0]       segment_in = '0;
  logic [N-1:0]     anode_in = '0;
  logic             clr_err = 1'b0;
  logic [4*N-1:0]   value_out;
  logic [N-1:0]     digit_valid;
  logic             frame_valid;
  logic             err_pattern;
  logic             err_anode;

  seven_seg_rx #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .segment_in  (segment_in),
    .anode_in    (anode_in),
    .clr_err     (clr_err),
    .value_out   (value_out),
    .digit_valid (digit_valid),
    .frame_valid (frame_valid),
    .err_pattern (err_pattern),
    .err_anode   (err_anode)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int fv_count = 0;

  // Reference model state
  int           seg_to_hex [int];
  logic [6:0]   glyphs [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [3:0]   m_digit [N];
  logic [N-1:0] m_valid;
  logic [4*N-1:0] m_value;
  logic         m_err_p, m_err_a;
  int           m_frames = 0;
  logic [N-1:0] last_an;
  logic [6:0]   last_seg;

  always @(negedge clk) if (frame_valid) fv_count++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) m_digit[k] = '0;
    m_valid  = '0;
    m_value  = '0;
    m_err_p  = 1'b0;
    m_err_a  = 1'b0;
    last_an  = '0;
    last_seg = '0;
  endtask

  // One held display state of len cycles: captured only if held long enough.
  task automatic model_hold(input logic [N-1:0] an, input logic [6:0] seg, input int len);
    int idx;
    if (len < S || an == 0) return;
    if ($countones(an) > 1) begin
      m_err_a = 1'b1;
      return;
    end
    if (!seg_to_hex.exists(int'(seg))) begin
      m_err_p = 1'b1;
      return;
    end
    idx = 0;
    for (int k = 0; k < N; k++) if (an[k]) idx = k;
    m_digit[idx] = 4'(seg_to_hex[int'(seg)]);
    m_valid[idx] = 1'b1;
    if (&m_valid) begin
      for (int k = 0; k < N; k++) m_value[4*k +: 4] = m_digit[k];
      m_valid = '0;
      m_frames++;
    end
  endtask

  task automatic compare_state(input string tag);
    check({tag, ".digit_valid"}, 32'(digit_valid), 32'(m_valid));
    check({tag, ".value_out"},   32'(value_out),   32'(m_value));
    check({tag, ".err_pattern"}, 32'(err_pattern), 32'(m_err_p));
    check({tag, ".err_anode"},   32'(err_anode),   32'(m_err_a));
    check({tag, ".frames"},      32'(fv_count),    32'(m_frames));
  endtask

  task automatic hold(input logic [N-1:0] an, input logic [6:0] seg, input int len, input string tag);
    anode_in   = an;
    segment_in = seg;
    repeat (len) @(negedge clk);
    model_hold(an, seg, len);
    last_an  = an;
    last_seg = seg;
    compare_state(tag);
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    m_err_p = 1'b0;
    m_err_a = 1'b0;
  endtask

  initial begin
    logic [N-1:0] an;
    logic [6:0]   seg;
    int           len;
    int           frames_before;

    for (int k = 0; k < 16; k++) seg_to_hex[int'(glyphs[k])] = k;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    compare_state("reset");
    check("reset.frame_valid", 32'(frame_valid), 32'd0);
    rst_n = 1'b1;

    // Rapid toggling never settles: no capture
    for (int t = 0; t < 10; t++) hold(4'b0001, (t % 2 == 0) ? 7'h3F : 7'h06, 2, "toggle");
    check("toggle.dv_zero", 32'(digit_valid), 32'd0);

    // Latency and single capture on a long hold
    frames_before = fv_count;
    anode_in   = 4'b0001;
    segment_in = 7'h7F;
    repeat (S + 1) @(negedge clk);
    check("latency.before", 32'(digit_valid), 32'd0);
    @(negedge clk);
    check("latency.at", 32'(digit_valid), 32'b0001);
    repeat (40 - S - 2) @(negedge clk);
    model_hold(4'b0001, 7'h7F, 40);
    compare_state("long_hold");
    check("long_hold.dv", 32'(digit_valid), 32'b0001);
    check("long_hold.no_frame", 32'(fv_count - frames_before), 32'd0);

    // Full scan of 0,1,2,3
    frames_before = fv_count;
    hold(4'b0001, 7'h3F, 8, "scan0");
    hold(4'b0010, 7'h06, 8, "scan1");
    hold(4'b0100, 7'h5B, 8, "scan2");
    hold(4'b1000, 7'h4F, 8, "scan3");
    check("scan.value", 32'(value_out), 32'h3210);
    check("scan.one_frame", 32'(fv_count - frames_before), 32'd1);
    check("scan.no_err", 32'({err_pattern, err_anode}), 32'd0);

    // Illegal pattern then clear
    hold(4'b0010, 7'h00, 8, "bad_pat");
    check("bad_pat.err", 32'(err_pattern), 32'd1);
    check("bad_pat.dv1", 32'(digit_valid[1]), 32'd0);
    pulse_clr();
    compare_state("clr_err");
    check("clr_err.err", 32'(err_pattern), 32'd0);

    // Multi-hot anode, then blanking
    hold(4'b0011, 7'h06, 8, "multi");
    check("multi.err", 32'(err_anode), 32'd1);
    check("multi.dv", 32'(digit_valid), 32'd0);
    hold(4'b0000, 7'h06, 8, "blank");
    check("blank.dv", 32'(digit_valid), 32'd0);

    // Reset after three digits of a new scan
    hold(4'b0001, 7'h3F, 8, "pre_rst0");
    hold(4'b0010, 7'h06, 8, "pre_rst1");
    hold(4'b0100, 7'h5B, 8, "pre_rst2");
    #2 rst_n = 1'b0;
    anode_in   = '0;
    segment_in = '0;
    #1;
    check("async_rst.value", 32'(value_out), 32'd0);
    check("async_rst.dv", 32'(digit_valid), 32'd0);
    check("async_rst.err", 32'({err_pattern, err_anode, frame_valid}), 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    hold(4'b0001, 7'h71, 8, "post_rst0");
    hold(4'b0010, 7'h79, 8, "post_rst1");
    hold(4'b0100, 7'h5E, 8, "post_rst2");
    check("post_rst.partial", 32'(value_out), 32'd0);
    hold(4'b1000, 7'h39, 8, "post_rst3");
    check("post_rst.value", 32'(value_out), 32'hCDEF);

    // Randomized scans
    for (int h = 0; h < 200; h++) begin
      do begin
        case ($urandom_range(0, 9))
          0:       an = '0;
          1: begin
            an = '0;
            an[$urandom_range(0, 1)] = 1'b1;
            an[$urandom_range(2, N - 1)] = 1'b1;
          end
          default: begin
            an = '0;
            an[$urandom_range(0, N - 1)] = 1'b1;
          end
        endcase
        if ($urandom_range(0, 4) == 0) seg = 7'($urandom);
        else                           seg = glyphs[$urandom_range(0, 15)];
      end while (an == last_an && seg == last_seg);
      if ($urandom_range(0, 2) == 0) len = $urandom_range(1, S - 1);
      else                           len = $urandom_range(S + 4, S + 12);
      hold(an, seg, len, "rand");
      if (len >= S && $urandom_range(0, 7) == 0) begin
        pulse_clr();
        compare_state("rand_clr");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
